// File: rtl/operator_slot_sequencer.sv
// operator_slot_sequencer: sweeps every bank/operator slot once per audio sample with fixed slot spacing and a drain tail
// inputs: sample_clk_en requests a sweep, clear_overrun clears the sticky overrun flag
// outputs: slot_en with bank_num/op_num/first_slot/last_slot per slot; busy, sweep_done pulse, overrun
module operator_slot_sequencer #(
  parameter int NUM_BANKS = 2,
  parameter int NUM_OPERATORS_PER_BANK = 18,
  parameter int SLOT_SPACING = 4,
  parameter int DRAIN_CYCLES = 2,
  localparam int BANK_NUM_WIDTH = (NUM_BANKS > 1) ? $clog2(NUM_BANKS) : 1,
  localparam int OP_NUM_WIDTH = (NUM_OPERATORS_PER_BANK > 1) ? $clog2(NUM_OPERATORS_PER_BANK) : 1
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      sample_clk_en,
  input  logic                      clear_overrun,
  output logic                      slot_en,
  output logic [BANK_NUM_WIDTH-1:0] bank_num,
  output logic [OP_NUM_WIDTH-1:0]   op_num,
  output logic                      first_slot,
  output logic                      last_slot,
  output logic                      busy,
  output logic                      sweep_done,
  output logic                      overrun
);
  typedef enum logic [1:0] {IDLE, ISSUE, GAP, DRAIN} state_t;
  localparam logic [BANK_NUM_WIDTH-1:0] LAST_BANK = BANK_NUM_WIDTH'(NUM_BANKS - 1);
  localparam logic [OP_NUM_WIDTH-1:0] LAST_OP = OP_NUM_WIDTH'(NUM_OPERATORS_PER_BANK - 1);
  state_t state, state_nxt;
  logic [3:0] gap_cnt;
  logic [2:0] drain_cnt;
  logic last, gap_end, drain_end, advance;
  always_comb begin
    last = bank_num == LAST_BANK && op_num == LAST_OP;
    gap_end = gap_cnt == 4'(SLOT_SPACING - 2);
    drain_end = drain_cnt == 3'(DRAIN_CYCLES - 1);
    state_nxt = state;
    case (state)
      IDLE:  state_nxt = sample_clk_en ? ISSUE : IDLE;
      ISSUE: state_nxt = last ? DRAIN : (SLOT_SPACING > 1) ? GAP : ISSUE;
      GAP:   state_nxt = gap_end ? ISSUE : GAP;
      DRAIN: state_nxt = drain_end ? IDLE : DRAIN;
      default: state_nxt = IDLE;
    endcase
    // indices move on entering the next ISSUE so they hold through GAP and DRAIN
    advance = (state == ISSUE && !last && SLOT_SPACING == 1) || (state == GAP && gap_end);
    slot_en = state == ISSUE;
    first_slot = slot_en && bank_num == '0 && op_num == '0;
    last_slot = slot_en && last;
    busy = state != IDLE;
    sweep_done = state == DRAIN && drain_end;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      gap_cnt <= '0;
      drain_cnt <= '0;
      bank_num <= '0;
      op_num <= '0;
      overrun <= 1'b0;
    end else begin
      state <= state_nxt;
      gap_cnt <= (state == GAP && !gap_end) ? gap_cnt + 4'd1 : 4'd0;
      drain_cnt <= (state == DRAIN && !drain_end) ? drain_cnt + 3'd1 : 3'd0;
      if (sweep_done) begin
        bank_num <= '0;
        op_num <= '0;
      end else if (advance) begin
        op_num <= (op_num == LAST_OP) ? '0 : op_num + 1'b1;
        bank_num <= bank_num + BANK_NUM_WIDTH'(op_num == LAST_OP);
      end
      // a request while busy (sweep_done cycle included) beats a coincident clear
      overrun <= (sample_clk_en && busy) || (overrun && !clear_overrun);
    end
  end
endmodule
